// File: rtl/fir_stream_ctrl.sv
// rtl/fir_stream_ctrl.sv - valid/ready streaming wrapper around a start/done FIR filter
//
// Samples enter through a small FIFO and are handed to the filter one at a time.
// Each filtered result is then presented downstream on a valid/ready stream.
//
// Ports:
//   clock, reset             rising-edge clock, asynchronous active-high reset
//   in_data/in_valid/in_ready    upstream sample stream into the FIFO
//   fir_start, fir_sample        one-cycle start pulse and held sample to the filter
//   fir_done, fir_result         filter completion level and result
//   out_data/out_valid/out_ready downstream result stream
//   timeout_err                  sticky flag: a filter run was abandoned
//   sample_count                 results delivered downstream, wrapping 16-bit

module fir_stream_ctrl #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              fir_start,
    output logic [DATA_W-1:0] fir_sample,
    input  logic              fir_done,
    input  logic [DATA_W-1:0] fir_result,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              timeout_err,
    output logic [15:0]       sample_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              done_q;
    logic [TMO_W-1:0]  wait_cnt;
    logic              push;
    logic              pop;
    logic              rise;

    // in_ready depends only on the registered count, never on in_valid.
    assign in_ready  = (count != CNT_W'(FIFO_DEPTH));
    assign push      = in_valid & in_ready;
    // The FIFO is only drained on the IDLE -> ISSUE transition.
    assign pop       = (state == S_IDLE) && (count != '0);
    // Edge detect: a done level already high when WAIT is entered is not a new result.
    assign rise      = fir_done & ~done_q;
    assign fir_start = (state == S_ISSUE);

    // Storage needs no reset; only pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= fir_done;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            fir_sample   <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            timeout_err  <= 1'b0;
            sample_count <= '0;
            wait_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        fir_sample <= mem[rd_ptr];
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (rise) begin
                        out_data  <= fir_result;
                        out_valid <= 1'b1;
                        state     <= S_HOLD;
                    end else if (wait_cnt == TMO_W'(TIMEOUT - 1)) begin
                        // Give up on this sample; the result is never delivered.
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid    <= 1'b0;
                        sample_count <= sample_count + 16'd1;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// tb/tb_fir_stream_ctrl.sv - self-checking bench for fir_stream_ctrl

module tb_fir_stream_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        fir_start;
    logic [15:0] fir_sample;
    logic        fir_done;
    logic [15:0] fir_result;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        timeout_err;
    logic [15:0] sample_count;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    fir_stream_ctrl #(.DATA_W(16), .FIFO_DEPTH(8), .TIMEOUT(64)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .fir_start    (fir_start),
        .fir_sample   (fir_sample),
        .fir_done     (fir_done),
        .fir_result   (fir_result),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .timeout_err  (timeout_err),
        .sample_count (sample_count)
    );

    // Filter model: result = sample + 0x1111, done after a latency, held a few cycles.
    logic        filt_en;
    int          fix_lat;
    logic        man_en;
    logic        man_done;
    logic [15:0] man_result;
    logic        auto_busy   = 1'b0;
    logic        auto_done   = 1'b0;
    logic [15:0] auto_result = 16'h0;
    logic [15:0] auto_smp    = 16'h0;
    int          auto_cnt    = 0;
    int          auto_lat    = 1;
    int          auto_hold   = 1;

    assign fir_done   = man_en ? man_done : auto_done;
    assign fir_result = man_en ? man_result : auto_result;

    always @(posedge clock) begin
        if (fir_start && filt_en) begin
            auto_busy <= 1'b1;
            auto_cnt  <= 0;
            auto_smp  <= fir_sample;
            auto_done <= 1'b0;
            auto_lat  <= (fix_lat != 0) ? fix_lat : int'($urandom_range(1, 6));
            auto_hold <= int'($urandom_range(1, 3));
        end else if (auto_busy) begin
            auto_cnt <= auto_cnt + 1;
            if (auto_cnt == auto_lat - 1) begin
                auto_done   <= 1'b1;
                auto_result <= 16'(auto_smp + 16'h1111);
            end
            if (auto_cnt == auto_lat - 1 + auto_hold) begin
                auto_done <= 1'b0;
                auto_busy <= 1'b0;
            end
        end
    end

    // Scoreboard: expected results in acceptance order, and what actually came out.
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];

    always @(negedge clock) begin
        if (!reset) begin
            if (in_valid && in_ready) exp_q.push_back(16'(in_data + 16'h1111));
            if (out_valid && out_ready) got_q.push_back(out_data);
        end
    end

    typedef struct {
        logic [15:0] smp;
        int          lat;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic wait_out(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_start(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (fir_start) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic push1(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        bit ok;
        bit seen_v;
        bit seen_s;
        int acc;
        int n;
        int e0;
        int g0;
        int ne;
        int ng;

        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = 16'h0;
        out_ready  = 1'b0;
        filt_en    = 1'b1;
        fix_lat    = 0;
        man_en     = 1'b0;
        man_done   = 1'b0;
        man_result = 16'h0;

        vecs[0] = '{16'h1234, 3, 16'h2345};
        vecs[1] = '{16'h9ABC, 5, 16'hABCD};
        vecs[2] = '{16'hFFFF, 1, 16'h1110};
        vecs[3] = '{16'h0000, 6, 16'h1111};
        vecs[4] = '{16'hEEEF, 2, 16'h0000};

        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_fir_start", 32'(fir_start), 32'd0);
        check("rst_fir_sample", 32'(fir_sample), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_sample_count", 32'(sample_count), 32'd0);
        reset = 1'b0;
        tick();

        // Single-sample runs from a table: start timing, sample, result, count.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fix_lat = vecs[i].lat;
            check("tbl_in_ready", 32'(in_ready), 32'd1);
            push1(vecs[i].smp);
            check("tbl_start_e0", 32'(fir_start), 32'd0);
            tick();
            check("tbl_start_e1", 32'(fir_start), 32'd1);
            check("tbl_fir_sample", 32'(fir_sample), 32'(vecs[i].smp));
            tick();
            check("tbl_start_e2", 32'(fir_start), 32'd0);
            wait_out(50, ok);
            check("tbl_out_seen", 32'(ok), 32'd1);
            check("tbl_out_data", 32'(out_data), 32'(vecs[i].exp_out));
            tick();
            check("tbl_out_one_cycle", 32'(out_valid), 32'd0);
            check("tbl_sample_count", 32'(sample_count), 32'(i + 1));
            check("tbl_fir_sample_hold", 32'(fir_sample), 32'(vecs[i].smp));
        end

        // Fill: one result parked in HOLD, then 10 back-to-back pushes.
        fix_lat   = 2;
        out_ready = 1'b0;
        e0 = exp_q.size();
        g0 = got_q.size();
        push1(16'h0A0A);
        wait_out(50, ok);
        check("fill_hold_seen", 32'(ok), 32'd1);
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = 16'(16'h0100 + k);
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        check("fill_accepted", 32'(acc), 32'd8);
        check("fill_in_ready_low", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 400 && (got_q.size() - g0) < 9; k++) tick();
        ne = exp_q.size() - e0;
        ng = got_q.size() - g0;
        check("fill_exp_count", 32'(ne), 32'd9);
        check("fill_got_count", 32'(ng), 32'd9);
        for (int k = 0; k < ng && k < ne; k++) begin
            check("fill_order", 32'(got_q[g0 + k]), 32'(exp_q[e0 + k]));
        end
        check("fill_sample_count", 32'(sample_count), 32'd14);
        check("fill_in_ready_back", 32'(in_ready), 32'd1);

        // Timeout: filter silent for the first of two queued samples.
        check("tmo_clear_before", 32'(timeout_err), 32'd0);
        filt_en  = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h5555;
        tick();
        in_data  = 16'h6666;
        tick();
        in_valid = 1'b0;
        wait_start(10, ok);
        check("tmo_first_start", 32'(ok), 32'd1);
        tick();
        n = 0;
        while (!timeout_err && n < 200) begin
            tick();
            n++;
        end
        check("tmo_wait_cycles", 32'(n), 32'd64);
        filt_en = 1'b1;
        fix_lat = 3;
        wait_start(10, ok);
        check("tmo_next_start", 32'(ok), 32'd1);
        check("tmo_next_sample", 32'(fir_sample), 32'h6666);
        wait_out(50, ok);
        check("tmo_next_out", 32'(ok), 32'd1);
        check("tmo_next_data", 32'(out_data), 32'h7777);
        tick();
        check("tmo_sticky", 32'(timeout_err), 32'd1);
        check("tmo_sample_count", 32'(sample_count), 32'd15);

        // Done held high across two runs; done pulses outside WAIT are ignored.
        man_en     = 1'b1;
        man_done   = 1'b0;
        man_result = 16'h0;
        push1(16'h0101);
        wait_start(10, ok);
        tick();
        man_result = 16'hC001;
        man_done   = 1'b1;
        wait_out(20, ok);
        check("held_first_out", 32'(out_data), 32'hC001);
        tick();
        check("held_first_done", 32'(out_valid), 32'd0);
        push1(16'h0202);
        wait_start(10, ok);
        check("held_second_start", 32'(ok), 32'd1);
        tick();
        man_result = 16'hC002;
        seen_v = 1'b0;
        for (int k = 0; k < 6; k++) begin
            seen_v |= out_valid;
            tick();
        end
        check("held_no_result_while_high", 32'(seen_v), 32'd0);
        out_ready = 1'b0;
        man_done  = 1'b0;
        tick();
        man_result = 16'hC003;
        man_done   = 1'b1;
        wait_out(20, ok);
        check("held_rerise_out", 32'(out_data), 32'hC003);
        man_done = 1'b0;
        tick();
        man_result = 16'hC004;
        man_done   = 1'b1;
        tick();
        tick();
        check("hold_pulse_valid", 32'(out_valid), 32'd1);
        check("hold_pulse_data", 32'(out_data), 32'hC003);
        out_ready = 1'b1;
        tick();
        check("hold_released", 32'(out_valid), 32'd0);
        man_done = 1'b0;
        tick();
        man_result = 16'hC005;
        man_done   = 1'b1;
        tick();
        tick();
        check("idle_pulse_valid", 32'(out_valid), 32'd0);
        check("idle_pulse_data", 32'(out_data), 32'hC003);
        check("held_sample_count", 32'(sample_count), 32'd17);
        man_done = 1'b0;
        tick();

        // Reset mid-run with three samples queued.
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 16'(16'h0301 + k);
            tick();
        end
        in_valid = 1'b0;
        check("rstrun_queue_busy", 32'(in_ready), 32'd1);
        reset = 1'b1;
        #1;
        check("rstrun_in_ready", 32'(in_ready), 32'd1);
        check("rstrun_out_valid", 32'(out_valid), 32'd0);
        check("rstrun_fir_start", 32'(fir_start), 32'd0);
        check("rstrun_fir_sample", 32'(fir_sample), 32'd0);
        check("rstrun_sample_count", 32'(sample_count), 32'd0);
        check("rstrun_timeout_err", 32'(timeout_err), 32'd0);
        tick();
        reset = 1'b0;
        man_result = 16'hDEAD;
        man_done   = 1'b1;
        seen_v = 1'b0;
        seen_s = 1'b0;
        for (int k = 0; k < 10; k++) begin
            seen_v |= out_valid;
            seen_s |= fir_start;
            tick();
        end
        check("rstrun_late_done_out", 32'(seen_v), 32'd0);
        check("rstrun_fifo_empty", 32'(seen_s), 32'd0);
        man_done = 1'b0;
        man_en   = 1'b0;
        tick();

        // Random traffic against the scoreboard.
        fix_lat = 0;
        filt_en = 1'b1;
        e0 = exp_q.size();
        g0 = got_q.size();
        for (int c = 0; c < 1500; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 600 && (got_q.size() - g0) < (exp_q.size() - e0); k++) tick();
        ne = exp_q.size() - e0;
        ng = got_q.size() - g0;
        check("rand_count", 32'(ng), 32'(ne));
        for (int k = 0; k < ng && k < ne; k++) begin
            check("rand_data", 32'(got_q[g0 + k]), 32'(exp_q[e0 + k]));
        end
        check("rand_sample_count", 32'(sample_count), 32'(ng));
        check("rand_no_timeout", 32'(timeout_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
